pla_sop_engine: RTL

PLA_SOP_ENGINE -- requirements
Module: pla_sop_engine

---
 rtl/pla_sop_if.sv | 33 +++
 rtl/pla_sop_engine.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pla_sop_if.sv
// Handshake and configuration bundle for pla_sop_engine.
// master = requester/configurator, slave = engine.
interface pla_sop_if #(
   parameter int NUM_IN    = 15,
   parameter int NUM_OUT   = 1,
   parameter int NUM_CUBES = 32
);
   localparam int AW = (NUM_CUBES > 1) ? $clog2(NUM_CUBES) : 1;

   logic                  cfg_we;
   logic                  cfg_ready;
   logic [AW-1:0]         cfg_addr;
   logic [2*NUM_IN-1:0]   cfg_lit;
   logic [NUM_OUT-1:0]    cfg_out;
   logic                  cfg_en;
   logic                  in_valid;
   logic                  in_ready;
   logic [NUM_IN-1:0]     in_x;
   logic                  out_valid;
   logic                  out_ready;
   logic [NUM_OUT-1:0]    out_y;
   logic                  busy;

   modport master (
      output cfg_we, cfg_addr, cfg_lit, cfg_out, cfg_en, in_valid, in_x, out_ready,
      input  cfg_ready, in_ready, out_valid, out_y, busy
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_lit, cfg_out, cfg_en, in_valid, in_x, out_ready,
      output cfg_ready, in_ready, out_valid, out_y, busy
   );
endinterface

// File: rtl/pla_sop_engine.sv
// Sequential PLA sum-of-products evaluator: scans a programmable cube table one entry per cycle.
// Optional macro PLA_SOP_EARLY_EXIT_EN ends the scan as soon as the accumulator is all-ones.
//
// state | meaning
// IDLE  | table writable, waiting for a request (in_ready=1)
// SCAN  | evaluating cube idx against latched input, table write-locked
// DONE  | result held on out_y with out_valid=1 until out_ready
module pla_sop_engine #(
   parameter int NUM_IN    = 15,
   parameter int NUM_OUT   = 1,
   parameter int NUM_CUBES = 32
) (
   input logic        clk,
   input logic        rst,
   pla_sop_if.slave   bus
);
   localparam int AW = (NUM_CUBES > 1) ? $clog2(NUM_CUBES) : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_CUBES - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                state, state_nxt;
   logic [AW-1:0]         idx;
   logic [NUM_IN-1:0]     x_lat;
   logic [NUM_OUT-1:0]    acc, acc_nxt;
   logic [2*NUM_IN-1:0]   lit_mem  [NUM_CUBES];
   logic [NUM_OUT-1:0]    mask_mem [NUM_CUBES];
   logic [NUM_CUBES-1:0]  en_bits;
   logic [2*NUM_IN-1:0]   lit_cur;
   logic                  match;
   logic                  wr;
   logic                  scan_end;

   assign wr = bus.cfg_we && bus.cfg_ready;

   // Literal/mask storage is deliberately unreset; only the enables gate matching.
   always_ff @(posedge clk) begin
      if (wr) begin
         lit_mem[bus.cfg_addr]  <= bus.cfg_lit;
         mask_mem[bus.cfg_addr] <= bus.cfg_out;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_bits <= '0;
      end else if (wr) begin
         en_bits[bus.cfg_addr] <= bus.cfg_en;
      end
   end

   // Literal pair bit 0 admits a 0 input, bit 1 admits a 1 input.
   always_comb begin
      lit_cur = lit_mem[idx];
      match   = en_bits[idx];
      for (int i = 0; i < NUM_IN; i++) begin
         match = match & (x_lat[i] ? lit_cur[2*i+1] : lit_cur[2*i]);
      end
      acc_nxt = acc | (match ? mask_mem[idx] : '0);
   end

`ifdef PLA_SOP_EARLY_EXIT_EN
   assign scan_end = (idx == LAST_IDX) || (&acc_nxt);
`else
   assign scan_end = (idx == LAST_IDX);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      bus.cfg_ready = 1'b1;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = SCAN;
         end
         SCAN: begin
            bus.busy      = 1'b1;
            bus.cfg_ready = 1'b0;
            if (scan_end) state_nxt = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx   <= '0;
         acc   <= '0;
         x_lat <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  x_lat <= bus.in_x;
                  acc   <= '0;
                  idx   <= '0;
               end
            end
            SCAN: begin
               acc <= acc_nxt;
               if (idx != LAST_IDX) idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // acc only moves in SCAN, so the DONE value stays put across legal table writes.
   assign bus.out_y = acc;

endmodule
